// File: rtl/writeback_arbiter_pkg.sv
// Shared write-back types: the producer request record, load funct3 encodings
// and the CSR address width.
package common;

    localparam int DATA_W     = 32;
    localparam int CSR_ADDR_W = 12;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]            rd;
        logic [DATA_W-1:0]     data;
        logic                  is_load;
        logic [2:0]            funct3;
        logic [1:0]            byte_off;
        logic                  csr_we;
        logic [CSR_ADDR_W-1:0] csr_addr;
        logic [DATA_W-1:0]     csr_wdata;
    } wb_req_t;

endpackage

// File: rtl/writeback_arbiter_formatter.sv
// Combinational load-data extension: selects the byte/half lane given by
// byte_off and sign- or zero-extends it according to funct3.
module load_formatter
    import common::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] ext
);

    logic [XLEN-1:0] lane;

    always_comb begin
        lane = data >> {byte_off, 3'b000};
        ext  = '0;
        case (funct3)
            F3_LB:  ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
            F3_LBU: ext = {{(XLEN-8){1'b0}}, lane[7:0]};
            F3_LW:  ext = data;
            // A halfword at byte 3 would straddle the word; it is trapped upstream.
            F3_LH:  if (byte_off != 2'd3) ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
            F3_LHU: if (byte_off != 2'd3) ext = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Multi-source write-back stage: one holding slot per producer, round-robin
// arbitration onto NUM_WR register-file ports and a single CSR write port.
module writeback_arbiter
    import common::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 3,
    parameter int NUM_WR  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              src_valid,
    output logic [NUM_SRC-1:0]              src_ready,
    input  wb_req_t [NUM_SRC-1:0]           src_req,
    output logic [NUM_WR-1:0]               rf_we,
    output logic [NUM_WR-1:0][4:0]          rf_waddr,
    output logic [NUM_WR-1:0][XLEN-1:0]     rf_wdata,
    output logic                            csr_we,
    output logic [CSR_ADDR_W-1:0]           csr_waddr,
    output logic [XLEN-1:0]                 csr_wdata,
    output logic                            idle
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]             full;
    wb_req_t [NUM_SRC-1:0]          slot;
    logic [IDX_W-1:0]               rr;
    logic [NUM_SRC-1:0]             grant;
    logic                           any_grant;
    int                             rr_next;
    logic [NUM_SRC-1:0][XLEN-1:0]   fmt_data;
    logic [NUM_SRC-1:0][XLEN-1:0]   wb_data;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fmt
        load_formatter #(.XLEN(XLEN)) u_fmt (
            .data     (slot[i].data),
            .funct3   (slot[i].funct3),
            .byte_off (slot[i].byte_off),
            .ext      (fmt_data[i])
        );
        assign wb_data[i] = slot[i].is_load ? fmt_data[i] : slot[i].data;
    end

    // Walk the slots in rotated order from rr; stop at the first full slot that
    // cannot be served so that nothing behind it overtakes it and starvation stays bounded.
    always_comb begin
        int  used;
        logic csr_taken;
        logic stop;
        used      = 0;
        csr_taken = 1'b0;
        stop      = 1'b0;
        grant     = '0;
        any_grant = 1'b0;
        rr_next   = int'(rr);
        rf_we     = '0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        csr_we    = 1'b0;
        csr_waddr = '0;
        csr_wdata = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!stop && full[j] && j == (int'(rr) + k) % NUM_SRC) begin
                    if (slot[j].csr_we && csr_taken) begin
                        stop = 1'b1;
                    end else if (slot[j].rd != 5'd0 && used >= NUM_WR) begin
                        stop = 1'b1;
                    end else begin
                        grant[j]  = 1'b1;
                        any_grant = 1'b1;
                        rr_next   = (j + 1) % NUM_SRC;
                        if (slot[j].csr_we) begin
                            csr_taken = 1'b1;
                            csr_we    = 1'b1;
                            csr_waddr = slot[j].csr_addr;
                            csr_wdata = slot[j].csr_wdata;
                        end
                        if (slot[j].rd != 5'd0) begin
                            for (int p = 0; p < NUM_WR; p++) begin
                                if (p == used) begin
                                    rf_we[p]    = 1'b1;
                                    rf_waddr[p] = slot[j].rd;
                                    rf_wdata[p] = wb_data[j];
                                end
                            end
                            used = used + 1;
                        end
                    end
                end
            end
        end
    end

    assign src_ready = ~full | grant;
    assign idle      = ~|full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
            slot <= '0;
            rr   <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    full[i] <= 1'b1;
                    slot[i] <= src_req[i];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
            if (any_grant) rr <= IDX_W'(rr_next);
        end
    end

endmodule
